decode_scoreboard: RTL and testbench

- Read-after-write hazard controller for the decode-stage register file (32 x 32-bit, 5-bit specifiers, one write port, two combinational read ports).
- Tracks outstanding writes per architectural register and stalls decode while a source operand is pending.
- Drives the register file write enable and write address from the writeback stage.
- Sits between the decode register file and the issue/writeback logic.

---
 rtl/decode_scoreboard.sv | 116 +++++++++++
 tb/tb_decode_scoreboard.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_scoreboard.sv
// Decode-stage RAW scoreboard: per-register pending-write counters,
// operand stall generation and writeback pass-through to the register file.
module decode_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2,
  parameter int TOT_W    = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec_valid,
  input  logic [ADDR_W-1:0]   dec_rs,
  input  logic [ADDR_W-1:0]   dec_rt,
  input  logic [ADDR_W-1:0]   dec_rd,
  input  logic                dec_uses_rt,
  input  logic                dec_writes,
  output logic                stall,
  output logic                issue,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rd,
  input  logic                flush,
  output logic                r_write,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [TOT_W-1:0]    pending_total,
  output logic                err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [TOT_W-1:0]    total_q;
  logic [TOT_W-1:0]    total_d;
  logic                err_q;
  logic                err_d;

  logic                rs_hit;
  logic                rt_hit;
  logic                rd_sat;
  logic                inc_any;
  logic                wb_hit;
  logic                wb_uf;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;

  // Hazards look only at registered counts; a same-cycle writeback
  // does not release a stall until the following cycle.
  always_comb begin
    rs_hit = (dec_rs != '0) && (cnt_q[dec_rs] != '0);
    rt_hit = dec_uses_rt && (dec_rt != '0) &&
             (cnt_q[dec_rt] != '0);
    rd_sat = dec_writes && (dec_rd != '0) &&
             (cnt_q[dec_rd] == CNT_MAX);
    stall  = dec_valid && (rs_hit || rt_hit || rd_sat);
    issue  = dec_valid && !stall && !flush;
  end

  assign r_write  = wb_valid;
  assign rf_waddr = wb_rd;

  always_comb begin
    inc_any = issue && dec_writes && (dec_rd != '0);
    wb_hit  = wb_valid && (wb_rd != '0) &&
              (cnt_q[wb_rd] != '0);
    wb_uf   = wb_valid && (wb_rd != '0) &&
              (cnt_q[wb_rd] == '0);
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      inc_vec[i] = inc_any && (dec_rd == ADDR_W'(i));
      dec_vec[i] = wb_hit && (wb_rd == ADDR_W'(i));
      cnt_d[i]   = cnt_q[i];
      if (inc_vec[i] && !dec_vec[i])
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (dec_vec[i] && !inc_vec[i])
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      if (flush || i == 0)
        cnt_d[i] = '0;
    end
  end

  always_comb begin
    total_d = total_q + TOT_W'(inc_any) - TOT_W'(wb_hit);
    if (flush)
      total_d = '0;
    err_d = err_q || wb_uf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        cnt_q[i] <= '0;
      total_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        cnt_q[i] <= cnt_d[i];
      total_q <= total_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < NUM_REGS; i++)
      busy_vec[i] = (cnt_q[i] != '0);
  end

  assign pending_total = total_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed bench for decode_scoreboard: RAW stall, saturation,
// issue/writeback collision, register 0, underflow, flush, async reset.
module tb_decode_scoreboard;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst;
  logic        dec_valid;
  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  logic [4:0]  dec_rd;
  logic        dec_uses_rt;
  logic        dec_writes;
  logic        stall;
  logic        issue;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        r_write;
  logic [4:0]  rf_waddr;
  logic [31:0] busy_vec;
  logic [6:0]  pending_total;
  logic        err_underflow;

  int checks = 0;
  int errors = 0;

  decode_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .dec_valid     (dec_valid),
    .dec_rs        (dec_rs),
    .dec_rt        (dec_rt),
    .dec_rd        (dec_rd),
    .dec_uses_rt   (dec_uses_rt),
    .dec_writes    (dec_writes),
    .stall         (stall),
    .issue         (issue),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .flush         (flush),
    .r_write       (r_write),
    .rf_waddr      (rf_waddr),
    .busy_vec      (busy_vec),
    .pending_total (pending_total),
    .err_underflow (err_underflow)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic ut, input logic w);
    dec_valid   = v;
    dec_rs      = rs;
    dec_rt      = rt;
    dec_rd      = rd;
    dec_uses_rt = ut;
    dec_writes  = w;
    #2;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rd);
    wb_valid = v;
    wb_rd    = rd;
    #2;
  endtask

  task automatic idle();
    flush = 1'b0;
    set_wb(1'b0, 5'd0);
    set_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    set_wb(1'b0, 5'd0);
    set_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #5 rst = 1'b1;
    #1;
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_total", 32'(pending_total), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_err", 32'(err_underflow), 0);
    chk("rst_issue", 32'(issue), 0);
    chk("rst_rwrite", 32'(r_write), 0);
    clk_en = 1'b1;
    step();
    step();
    rst = 1'b0;

    // basic RAW on r5
    set_dec(1, 0, 0, 5, 0, 1);
    chk("raw_c0_issue", 32'(issue), 1);
    step();
    set_dec(1, 5, 0, 0, 0, 0);
    chk("raw_c1_busy5", 32'(busy_vec[5]), 1);
    chk("raw_c1_stall", 32'(stall), 1);
    chk("raw_c1_issue", 32'(issue), 0);
    chk("raw_c1_total", 32'(pending_total), 1);
    step();
    chk("raw_c2_stall", 32'(stall), 1);
    step();
    set_wb(1, 5);
    chk("raw_c3_stall", 32'(stall), 1);
    chk("raw_c3_rwrite", 32'(r_write), 1);
    chk("raw_c3_waddr", 32'(rf_waddr), 5);
    step();
    set_wb(0, 0);
    chk("raw_c4_stall", 32'(stall), 0);
    chk("raw_c4_issue", 32'(issue), 1);
    chk("raw_c4_busy", busy_vec, 0);
    chk("raw_c4_total", 32'(pending_total), 0);
    step();
    idle();

    // saturation on r7
    for (int k = 0; k < 3; k++) begin
      set_dec(1, 0, 0, 7, 0, 1);
      chk("sat_issue", 32'(issue), 1);
      step();
    end
    chk("sat_total3", 32'(pending_total), 3);
    chk("sat_busy", busy_vec, 32'h80);
    chk("sat_4th_stall", 32'(stall), 1);
    chk("sat_4th_issue", 32'(issue), 0);
    step();
    chk("sat_hold", 32'(stall), 1);
    set_wb(1, 7);
    chk("sat_wb_stall", 32'(stall), 1);
    step();
    set_wb(0, 0);
    chk("sat_total2", 32'(pending_total), 2);
    chk("sat_release", 32'(issue), 1);
    step();
    idle();
    chk("sat_total_after", 32'(pending_total), 3);
    set_dec(1, 0, 0, 7, 0, 1);
    chk("sat_again_stall", 32'(stall), 1);
    idle();
    for (int k = 0; k < 3; k++) begin
      set_wb(1, 7);
      step();
    end
    idle();
    chk("sat_drained", 32'(pending_total), 0);
    chk("sat_err", 32'(err_underflow), 0);

    // rt only hazards when dec_uses_rt
    set_dec(1, 0, 0, 10, 0, 1);
    step();
    set_dec(1, 0, 10, 0, 0, 0);
    chk("rt_unused", 32'(stall), 0);
    set_dec(1, 0, 10, 0, 1, 0);
    chk("rt_used", 32'(stall), 1);
    set_dec(1, 10, 0, 0, 0, 0);
    chk("rs_busy", 32'(stall), 1);
    idle();
    set_wb(1, 10);
    step();
    idle();
    chk("rt_drained", 32'(pending_total), 0);

    // simultaneous issue and writeback on r9
    set_dec(1, 0, 0, 9, 0, 1);
    step();
    set_dec(1, 0, 0, 9, 0, 1);
    set_wb(1, 9);
    chk("sim_issue", 32'(issue), 1);
    step();
    idle();
    chk("sim_total", 32'(pending_total), 1);
    chk("sim_busy", busy_vec, 32'h200);
    set_wb(1, 9);
    step();
    idle();
    chk("sim_drained", 32'(pending_total), 0);

    // register 0 is never tracked
    set_dec(1, 0, 0, 0, 0, 1);
    chk("r0_issue", 32'(issue), 1);
    step();
    set_dec(1, 0, 0, 0, 1, 0);
    chk("r0_stall", 32'(stall), 0);
    chk("r0_total", 32'(pending_total), 0);
    chk("r0_busy", busy_vec, 0);
    idle();
    set_wb(1, 0);
    chk("r0_rwrite", 32'(r_write), 1);
    chk("r0_waddr", 32'(rf_waddr), 0);
    step();
    idle();
    chk("r0_wb_err", 32'(err_underflow), 0);
    chk("r0_wb_total", 32'(pending_total), 0);

    // underflow
    set_wb(1, 12);
    step();
    idle();
    chk("uf_err", 32'(err_underflow), 1);
    chk("uf_total", 32'(pending_total), 0);
    chk("uf_busy", busy_vec, 0);
    step();
    step();
    chk("uf_sticky", 32'(err_underflow), 1);

    // flush with concurrent issue and writeback
    set_dec(1, 0, 0, 3, 0, 1);
    step();
    set_dec(1, 0, 0, 4, 0, 1);
    step();
    set_dec(1, 0, 0, 20, 0, 1);
    step();
    idle();
    chk("fl_pre_total", 32'(pending_total), 3);
    chk("fl_pre_busy", busy_vec, 32'h0010_0018);
    flush = 1'b1;
    set_wb(1, 3);
    set_dec(1, 0, 0, 8, 0, 1);
    chk("fl_issue", 32'(issue), 0);
    chk("fl_rwrite", 32'(r_write), 1);
    chk("fl_waddr", 32'(rf_waddr), 3);
    step();
    idle();
    chk("fl_busy", busy_vec, 0);
    chk("fl_total", 32'(pending_total), 0);
    chk("fl_err_kept", 32'(err_underflow), 1);
    set_dec(1, 8, 0, 0, 0, 0);
    chk("fl_r8_free", 32'(stall), 0);
    idle();

    // asynchronous reset mid-cycle
    set_dec(1, 0, 0, 6, 0, 1);
    step();
    idle();
    chk("ar_busy_pre", busy_vec, 32'h40);
    rst = 1'b1;
    #1;
    chk("ar_busy", busy_vec, 0);
    chk("ar_total", 32'(pending_total), 0);
    chk("ar_err", 32'(err_underflow), 0);
    step();
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
